// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator with a pixel fetch strobe and
// de/hsync/vsync/frame_start delayed to line up with the pixel source latency.
module video_timing_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP = 33,
   parameter logic H_POL = 1'b0,
   parameter logic V_POL = 1'b0,
   parameter int DATA_LAT = 1
) (
   input logic sys_clk,
   input logic sys_rst_n,
   input logic en,
   output logic pix_req,
   output logic [11:0] pix_x,
   output logic [11:0] pix_y,
   output logic de,
   output logic hsync,
   output logic vsync,
   output logic frame_start,
   output logic busy
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
   localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
   localparam logic [11:0] H_SS = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] V_SS = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] H_SE = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] V_SE = 12'(V_ACTIVE + V_FP + V_SYNC);
   if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_total_chk
      $error("video_timing_ctrl: H_TOTAL/V_TOTAL exceed 4095");
   end
   if (DATA_LAT < 0 || DATA_LAT > 7) begin : g_lat_chk
      $error("video_timing_ctrl: DATA_LAT out of range 0..7");
   end
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;
   logic [11:0] h_cnt, v_cnt;
   logic eof, raw_de, raw_hs, raw_vs, raw_fs;
   logic [DATA_LAT:0][3:0] pipe;
   assign eof = h_cnt == H_LAST && v_cnt == V_LAST;
   always_ff @(posedge sys_clk or posedge sys_rst_n) begin
      if (sys_rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   // DRAIN only ever leaves at end of frame, so en is ignored there
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (en ? RUN : IDLE) :
                  (state == RUN && en) ? RUN : eof ? IDLE : DRAIN;
   end
   always_ff @(posedge sys_clk or posedge sys_rst_n) begin
      if (sys_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (state == IDLE) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 12'd1;
         if (h_cnt == H_LAST) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
      end
   end
   assign busy = state != IDLE;
   assign raw_de = busy && h_cnt < H_ACT && v_cnt < V_ACT;
   assign raw_hs = busy && h_cnt >= H_SS && h_cnt < H_SE;
   assign raw_vs = busy && v_cnt >= V_SS && v_cnt < V_SE;
   assign raw_fs = state == RUN && h_cnt == '0 && v_cnt == '0;
   assign pix_req = raw_de;
   assign pix_x = raw_de ? h_cnt : '0;
   assign pix_y = raw_de ? v_cnt : '0;
   // Stage 0 registers the raw timing; DATA_LAT further stages match the pixel source
   always_ff @(posedge sys_clk or posedge sys_rst_n) begin
      if (sys_rst_n) pipe <= '0;
      else begin
         pipe[0] <= {raw_fs, raw_vs, raw_hs, raw_de};
         for (int i = 1; i <= DATA_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign de = pipe[DATA_LAT][0];
   assign hsync = pipe[DATA_LAT][1] ^ ~H_POL;
   assign vsync = pipe[DATA_LAT][2] ^ ~V_POL;
   assign frame_start = pipe[DATA_LAT][3];
endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16: horizontal front porch, in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync width, in clocks.
REQ-004 SHALL have parameter H_BP, default 48: horizontal back porch, in clocks.
REQ-005 SHALL have parameters V_ACTIVE / V_FP / V_SYNC / V_BP, defaults 480 / 10 / 2 / 33: vertical equivalents, in lines.
REQ-006 SHALL have parameters H_POL and V_POL, default 0: sync asserted level (0 = active-low).
REQ-007 SHALL have parameter DATA_LAT, default 1, range 0..7: pixel-source latency from pix_req to data.
REQ-008 SHALL use clock sys_clk and reset sys_rst_n (asynchronous, active-high): reset sys_rst_n, asynchronous, active-high; clock sys_clk.
REQ-009 SHALL have ports:
- sys_clk, input, 1 bit: pixel clock.
- sys_rst_n, input, 1 bit: asynchronous active-high reset.
- en, input, 1 bit: run request.
- pix_req, output, 1 bit: pixel fetch strobe.
- pix_x, output, 12 bits: column of the requested pixel.
- pix_y, output, 12 bits: row of the requested pixel.
- de, output, 1 bit: to encoder de.
- hsync, output, 1 bit: to channel-0 c0.
- vsync, output, 1 bit: to channel-0 c1.
- frame_start, output, 1 bit: one-cycle pulse.
- busy, output, 1 bit: state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, RUN and DRAIN.
REQ-011 IDLE -> RUN on the first cycle with en=1; h_cnt=0 and v_cnt=0 in the first RUN cycle.
REQ-012 RUN -> DRAIN when en=0 is sampled while not on the last cycle of the frame.
REQ-013 RUN or DRAIN -> IDLE at the end of the frame when en=0.
REQ-014 DRAIN -> RUN is not permitted; en=1 during DRAIN is ignored until IDLE is reached.
REQ-015 RUN continues into the next frame at the end of the frame when en=1.
REQ-016 h_cnt SHALL be 12-bit, counting 0..H_TOTAL-1 with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, and wrap to 0.
REQ-017 v_cnt SHALL be 12-bit and increment only when h_cnt wraps, counting 0..V_TOTAL-1 (V_TOTAL = sum of the V parameters) and wrapping to 0.
REQ-018 End of frame SHALL be h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1.
REQ-019 Regions per axis SHALL be: active [0, ACTIVE); front porch [ACTIVE, ACTIVE+FP); sync [ACTIVE+FP, ACTIVE+FP+SYNC); back porch for the remainder.
REQ-020 Raw de SHALL be (h in active) AND (v in active), gated by state is not IDLE.
REQ-021 Raw hsync SHALL be asserted during h sync region; raw vsync SHALL be asserted for the full lines in v sync region.
REQ-022 pix_req SHALL equal raw de, combinational from the counters.
REQ-023 pix_x and pix_y SHALL equal h_cnt and v_cnt when pix_req=1, and SHALL be 0 otherwise.
REQ-024 de, hsync and vsync SHALL be raw values registered and then delayed by DATA_LAT further cycles, giving DATA_LAT+1 cycles total after pix_req.
REQ-025 hsync and vsync SHALL XOR their raw value with ~H_POL and ~V_POL respectively, so they idle at the inactive level.
REQ-026 frame_start SHALL pulse for exactly one cycle, aligned with the delayed outputs, for the cycle where h_cnt=0 and v_cnt=0 in RUN.
REQ-027 In IDLE, counters SHALL hold 0; pix_req=0; de=0; syncs at the inactive level after the delay line flushes.
REQ-028 Delay-line contents SHALL always drain, so the last active pixel is never truncated on the IDLE transition.
REQ-029 All arithmetic SHALL be unsigned 12-bit; H_TOTAL and V_TOTAL SHALL be ≤ 4095, checked by elaboration-time assertion.

Reset
REQ-030 On sys_rst_n=1 (asynchronous), the state SHALL go to IDLE.
REQ-031 On reset, h_cnt, v_cnt, the delay line and de SHALL clear to 0.
REQ-032 On reset, hsync and vsync SHALL go to the inactive level; pix_req, pix_x, pix_y and frame_start SHALL be 0; busy SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately, with no drain.
REQ-034 After reset release, the first RUN cycle SHALL be the first sys_clk edge with en=1.

Verification
Small configuration for all scenarios: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); DATA_LAT=2; polarities 0.
REQ-035 SHALL cover: en=1 from reset -> pix_req high for cycles 0-3 of each line, pix_x 0..3, lines 0-2 only; de mirrors this 3 cycles later; 12 pix_req per frame.
REQ-036 SHALL cover: timing check -> hsync low for h_cnt 5-6 (delayed 3 cycles); vsync low for all 8 cycles of line 4; frame_start every 48 cycles.
REQ-037 SHALL cover: en dropped at h_cnt=2, v_cnt=1 -> busy stays 1 until the end of line 5; the remaining 6 pixels are still requested; then IDLE, de=0, hsync=vsync=1.
REQ-038 SHALL cover: en re-asserted during DRAIN -> ignored; a new frame starts only after IDLE, with h_cnt=v_cnt=0.
REQ-039 SHALL cover: sys_rst_n pulsed at h_cnt=1, v_cnt=0 -> all outputs reset immediately; no pending de emerges from the delay line.
REQ-040 SHALL cover: DATA_LAT=0 -> de lags pix_req by exactly 1 cycle; back-to-back frames show no gap cycle at the wrap.
